// File: rtl/id_ex_stage_pkg.sv
// Shared decode constants and types for the ID/EX pipeline register and the ALU.
//   opcode_e  : primary opcodes understood by the decoder
//   alu_sig_e : ALU Signal codes carried into EX
//   ctrl_t    : decoded control bundle for one ID instruction
//   decode()  : opcode/funct -> ctrl_t (valid=0 means "load a bubble")
package id_ex_stage_pkg;

    typedef enum logic [5:0] {
        OP_RTYPE = 6'd0,
        OP_BEQ   = 6'd4,
        OP_ADDI  = 6'd8,
        OP_LW    = 6'd35,
        OP_SW    = 6'd43
    } opcode_e;

    typedef enum logic [5:0] {
        SIG_NONE = 6'd0,
        SIG_ADD  = 6'd32,
        SIG_SUB  = 6'd34,
        SIG_AND  = 6'd36,
        SIG_OR   = 6'd37,
        SIG_SLT  = 6'd42
    } alu_sig_e;

    typedef struct packed {
        logic       valid;
        logic       regwrite;
        logic       memread;
        logic       memwrite;
        logic       branch;
        logic       use_imm;
        logic       reads_rt;
        logic       dest_is_rt;
        logic [5:0] signal;
    } ctrl_t;

    function automatic ctrl_t decode(input logic [5:0] opcode, input logic [5:0] funct);
        ctrl_t c;
        c = '0;
        case (opcode)
            OP_RTYPE: begin
                // rt is read even when funct is unsupported; hazard detection stays conservative
                c.reads_rt = 1'b1;
                case (funct)
                    SIG_ADD, SIG_SUB, SIG_AND, SIG_OR, SIG_SLT: begin
                        c.valid    = 1'b1;
                        c.regwrite = 1'b1;
                        c.signal   = funct;
                    end
                    default: c.valid = 1'b0;
                endcase
            end
            OP_LW: begin
                c.valid      = 1'b1;
                c.regwrite   = 1'b1;
                c.memread    = 1'b1;
                c.use_imm    = 1'b1;
                c.dest_is_rt = 1'b1;
                c.signal     = SIG_ADD;
            end
            OP_SW: begin
                c.valid    = 1'b1;
                c.memwrite = 1'b1;
                c.use_imm  = 1'b1;
                c.reads_rt = 1'b1;
                c.signal   = SIG_ADD;
            end
            OP_BEQ: begin
                c.valid    = 1'b1;
                c.branch   = 1'b1;
                c.reads_rt = 1'b1;
                c.signal   = SIG_SUB;
            end
            OP_ADDI: begin
                c.valid      = 1'b1;
                c.regwrite   = 1'b1;
                c.use_imm    = 1'b1;
                c.dest_is_rt = 1'b1;
                c.signal     = SIG_ADD;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/id_ex_stage_fwd_mux.sv
// Per-operand forwarding selector.
//   src           : register index of the operand held in EX
//   file_data     : register-file value captured at ID
//   exmem_*       : EX/MEM write-back candidate (highest priority)
//   memwb_*       : MEM/WB write-back candidate
//   operand       : resolved operand value; register 0 always reads 0
module fwd_mux #(
    parameter int unsigned DW = 32,
    parameter int unsigned RW = 5
) (
    input  logic [RW-1:0] src,
    input  logic [DW-1:0] file_data,
    input  logic          exmem_regwrite,
    input  logic [RW-1:0] exmem_rd,
    input  logic [DW-1:0] exmem_result,
    input  logic          memwb_regwrite,
    input  logic [RW-1:0] memwb_rd,
    input  logic [DW-1:0] memwb_result,
    output logic [DW-1:0] operand
);

    // src==0 short-circuits, which also covers the rd!=0 qualifier on both paths
    always_comb begin
        operand = file_data;
        if (src == '0)
            operand = '0;
        else if (exmem_regwrite && (exmem_rd == src))
            operand = exmem_result;
        else if (memwb_regwrite && (memwb_rd == src))
            operand = memwb_result;
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with decode, load-use hazard detection and
// EX-stage operand forwarding.
//   clk, reset             : rising-edge clock, asynchronous active-low reset
//   id_*                   : decoded-slot instruction fields and register-file data
//   flush                  : kill the instruction entering EX
//   exmem_*, memwb_*       : write-back candidates used for forwarding
//   stall                  : hold PC and IF/ID (combinational)
//   ex_valid..ex_branch    : registered EX controls
//   ex_signal, ex_dest     : registered ALU Signal code and destination register
//   ex_dataA/B, ex_store_data : forwarded operands
module id_ex_stage
    import id_ex_stage_pkg::*;
#(
    parameter int unsigned DW = 32,
    parameter int unsigned RW = 5
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          id_valid,
    input  logic [5:0]    id_opcode,
    input  logic [5:0]    id_funct,
    input  logic [RW-1:0] id_rs,
    input  logic [RW-1:0] id_rt,
    input  logic [RW-1:0] id_rd,
    input  logic [DW-1:0] id_rs_data,
    input  logic [DW-1:0] id_rt_data,
    input  logic [15:0]   id_imm,
    input  logic          flush,
    input  logic          exmem_regwrite,
    input  logic [RW-1:0] exmem_rd,
    input  logic [DW-1:0] exmem_result,
    input  logic          memwb_regwrite,
    input  logic [RW-1:0] memwb_rd,
    input  logic [DW-1:0] memwb_result,
    output logic          stall,
    output logic          ex_valid,
    output logic          ex_regwrite,
    output logic          ex_memread,
    output logic          ex_memwrite,
    output logic          ex_branch,
    output logic [5:0]    ex_signal,
    output logic [DW-1:0] ex_dataA,
    output logic [DW-1:0] ex_dataB,
    output logic [DW-1:0] ex_store_data,
    output logic [RW-1:0] ex_dest
);

    ctrl_t         id_ctrl;
    logic          load_use;
    logic          load_ex;
    logic [RW-1:0] ex_rs;
    logic [RW-1:0] ex_rt;
    logic [DW-1:0] rs_q;
    logic [DW-1:0] rt_q;
    logic [DW-1:0] imm_q;
    logic          use_imm_q;
    logic [DW-1:0] fwd_rs;
    logic [DW-1:0] fwd_rt;

    always_comb begin
        id_ctrl  = decode(id_opcode, id_funct);
        load_use = ex_valid && ex_memread && (ex_dest != '0) && id_valid &&
                   ((ex_dest == id_rs) || ((ex_dest == id_rt) && id_ctrl.reads_rt));
        // reset gates stall directly so it is low for the whole reset interval
        stall    = reset && !flush && load_use;
        load_ex  = id_valid && id_ctrl.valid && !flush && !load_use;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ex_valid    <= 1'b0;
            ex_regwrite <= 1'b0;
            ex_memread  <= 1'b0;
            ex_memwrite <= 1'b0;
            ex_branch   <= 1'b0;
            ex_signal   <= '0;
            ex_dest     <= '0;
            ex_rs       <= '0;
            ex_rt       <= '0;
            rs_q        <= '0;
            rt_q        <= '0;
            imm_q       <= '0;
            use_imm_q   <= 1'b0;
        end else begin
            ex_valid    <= load_ex;
            ex_regwrite <= load_ex && id_ctrl.regwrite;
            ex_memread  <= load_ex && id_ctrl.memread;
            ex_memwrite <= load_ex && id_ctrl.memwrite;
            ex_branch   <= load_ex && id_ctrl.branch;
            // Data fields load unconditionally; a bubble only has to neutralise controls
            ex_signal   <= id_ctrl.signal;
            ex_dest     <= id_ctrl.dest_is_rt ? id_rt : id_rd;
            ex_rs       <= id_rs;
            ex_rt       <= id_rt;
            rs_q        <= id_rs_data;
            rt_q        <= id_rt_data;
            imm_q       <= {{(DW-16){id_imm[15]}}, id_imm};
            use_imm_q   <= id_ctrl.use_imm;
        end
    end

    fwd_mux #(.DW(DW), .RW(RW)) u_fwd_rs (
        .src            (ex_rs),
        .file_data      (rs_q),
        .exmem_regwrite (exmem_regwrite),
        .exmem_rd       (exmem_rd),
        .exmem_result   (exmem_result),
        .memwb_regwrite (memwb_regwrite),
        .memwb_rd       (memwb_rd),
        .memwb_result   (memwb_result),
        .operand        (fwd_rs)
    );

    fwd_mux #(.DW(DW), .RW(RW)) u_fwd_rt (
        .src            (ex_rt),
        .file_data      (rt_q),
        .exmem_regwrite (exmem_regwrite),
        .exmem_rd       (exmem_rd),
        .exmem_result   (exmem_result),
        .memwb_regwrite (memwb_regwrite),
        .memwb_rd       (memwb_rd),
        .memwb_result   (memwb_result),
        .operand        (fwd_rt)
    );

    always_comb begin
        ex_dataA      = fwd_rs;
        ex_dataB      = use_imm_q ? imm_q : fwd_rt;
        ex_store_data = fwd_rt;
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: decode, forwarding priority, load-use stall,
// flush priority and asynchronous reset.
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        id_valid;
    logic [5:0]  id_opcode, id_funct;
    logic [4:0]  id_rs, id_rt, id_rd;
    logic [31:0] id_rs_data, id_rt_data;
    logic [15:0] id_imm;
    logic        flush;
    logic        exmem_regwrite, memwb_regwrite;
    logic [4:0]  exmem_rd, memwb_rd;
    logic [31:0] exmem_result, memwb_result;
    logic        stall, ex_valid, ex_regwrite, ex_memread, ex_memwrite, ex_branch;
    logic [5:0]  ex_signal;
    logic [31:0] ex_dataA, ex_dataB, ex_store_data;
    logic [4:0]  ex_dest;

    int passed = 0;
    int failed = 0;
    int total  = 0;

    id_ex_stage #(.DW(32), .RW(5)) dut (
        .clk            (clk),
        .reset          (reset),
        .id_valid       (id_valid),
        .id_opcode      (id_opcode),
        .id_funct       (id_funct),
        .id_rs          (id_rs),
        .id_rt          (id_rt),
        .id_rd          (id_rd),
        .id_rs_data     (id_rs_data),
        .id_rt_data     (id_rt_data),
        .id_imm         (id_imm),
        .flush          (flush),
        .exmem_regwrite (exmem_regwrite),
        .exmem_rd       (exmem_rd),
        .exmem_result   (exmem_result),
        .memwb_regwrite (memwb_regwrite),
        .memwb_rd       (memwb_rd),
        .memwb_result   (memwb_result),
        .stall          (stall),
        .ex_valid       (ex_valid),
        .ex_regwrite    (ex_regwrite),
        .ex_memread     (ex_memread),
        .ex_memwrite    (ex_memwrite),
        .ex_branch      (ex_branch),
        .ex_signal      (ex_signal),
        .ex_dataA       (ex_dataA),
        .ex_dataB       (ex_dataB),
        .ex_store_data  (ex_store_data),
        .ex_dest        (ex_dest)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [5:0] op, input logic [5:0] fn,
                         input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                         input logic [31:0] rsd, input logic [31:0] rtd, input logic [15:0] imm);
        id_valid   = v;
        id_opcode  = op;
        id_funct   = fn;
        id_rs      = rs;
        id_rt      = rt;
        id_rd      = rd;
        id_rs_data = rsd;
        id_rt_data = rtd;
        id_imm     = imm;
    endtask

    task automatic set_wb(input logic ew, input logic [4:0] erd, input logic [31:0] eres,
                          input logic mw, input logic [4:0] mrd, input logic [31:0] mres);
        exmem_regwrite = ew;
        exmem_rd       = erd;
        exmem_result   = eres;
        memwb_regwrite = mw;
        memwb_rd       = mrd;
        memwb_result   = mres;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b0;
        flush = 1'b0;
        set_wb(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        drive(1'b1, 6'd0, 6'd32, 5'd1, 5'd2, 5'd3, 32'd5, 32'd7, 16'd0);

        // reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", ex_valid, 0);
        check("rst_regwrite", ex_regwrite, 0);
        check("rst_memread", ex_memread, 0);
        check("rst_memwrite", ex_memwrite, 0);
        check("rst_branch", ex_branch, 0);
        check("rst_signal", ex_signal, 0);
        check("rst_dest", ex_dest, 0);
        check("rst_dataA", ex_dataA, 0);
        check("rst_dataB", ex_dataB, 0);
        check("rst_stall", stall, 0);

        // add $3,$1,$2 loads on first edge after release
        reset = 1'b1;
        tick();
        check("add_valid", ex_valid, 1);
        check("add_signal", ex_signal, 32);
        check("add_dataA", ex_dataA, 5);
        check("add_dataB", ex_dataB, 7);
        check("add_dest", ex_dest, 3);
        check("add_regwrite", ex_regwrite, 1);
        check("add_memread", ex_memread, 0);

        // forwarding priority on the add in EX
        set_wb(1'b1, 5'd1, 32'd100, 1'b1, 5'd1, 32'd200);
        #1 check("fwd_exmem_wins", ex_dataA, 100);
        set_wb(1'b1, 5'd0, 32'd9, 1'b0, 5'd0, 32'd0);
        #1 check("fwd_rd0_none", ex_dataA, 5);
        set_wb(1'b0, 5'd0, 32'd0, 1'b1, 5'd2, 32'd55);
        #1 check("fwd_memwb_B", ex_dataB, 55);
        check("fwd_memwb_store", ex_store_data, 55);
        set_wb(1'b1, 5'd2, 32'd66, 1'b1, 5'd2, 32'd55);
        #1 check("fwd_exmem_B", ex_dataB, 66);
        set_wb(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);

        // addi $2,$0,-1
        drive(1'b1, 6'd8, 6'd0, 5'd0, 5'd2, 5'd0, 32'h12345678, 32'd0, 16'hFFFF);
        tick();
        check("addi_dataB", ex_dataB, 32'hFFFFFFFF);
        check("addi_signal", ex_signal, 32);
        check("addi_dest", ex_dest, 2);
        check("addi_regwrite", ex_regwrite, 1);
        check("addi_dataA_r0", ex_dataA, 0);

        // R-type funct 0 -> bubble
        drive(1'b1, 6'd0, 6'd0, 5'd1, 5'd2, 5'd3, 32'd1, 32'd2, 16'd0);
        tick();
        check("f0_valid", ex_valid, 0);
        check("f0_regwrite", ex_regwrite, 0);

        // unknown opcode -> bubble
        drive(1'b1, 6'd2, 6'd0, 5'd1, 5'd2, 5'd3, 32'd1, 32'd2, 16'd0);
        tick();
        check("badop_valid", ex_valid, 0);

        // id_valid=0 -> bubble
        drive(1'b0, 6'd0, 6'd32, 5'd1, 5'd2, 5'd3, 32'd1, 32'd2, 16'd0);
        tick();
        check("idinv_valid", ex_valid, 0);
        check("idinv_regwrite", ex_regwrite, 0);

        // beq $1,$2
        drive(1'b1, 6'd4, 6'd0, 5'd1, 5'd2, 5'd0, 32'd9, 32'd9, 16'd3);
        tick();
        check("beq_branch", ex_branch, 1);
        check("beq_signal", ex_signal, 34);
        check("beq_regwrite", ex_regwrite, 0);
        check("beq_dataB", ex_dataB, 9);

        // lw $4,8($1)
        drive(1'b1, 6'd35, 6'd0, 5'd1, 5'd4, 5'd0, 32'd100, 32'd0, 16'd8);
        tick();
        check("lw_memread", ex_memread, 1);
        check("lw_regwrite", ex_regwrite, 1);
        check("lw_dest", ex_dest, 4);
        check("lw_dataA", ex_dataA, 100);
        check("lw_dataB", ex_dataB, 8);

        // sub $5,$4,$6 -> load-use stall, bubble, then MEM/WB forward
        drive(1'b1, 6'd0, 6'd34, 5'd4, 5'd6, 5'd5, 32'h0000AAAA, 32'd3, 16'd0);
        #1 check("lu_stall", stall, 1);
        tick();
        check("lu_bubble_valid", ex_valid, 0);
        check("lu_bubble_regwrite", ex_regwrite, 0);
        check("lu_bubble_memread", ex_memread, 0);
        check("lu_stall_clear", stall, 0);
        set_wb(1'b0, 5'd0, 32'd0, 1'b1, 5'd4, 32'd77);
        tick();
        check("sub_valid", ex_valid, 1);
        check("sub_signal", ex_signal, 34);
        check("sub_dest", ex_dest, 5);
        check("sub_dataA_fwd", ex_dataA, 77);
        check("sub_dataB", ex_dataB, 3);
        set_wb(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);

        // lw $4 again: addi writes rt (no stall), sw reads rt (stall), flush overrides
        drive(1'b1, 6'd35, 6'd0, 5'd1, 5'd4, 5'd0, 32'd100, 32'd0, 16'd8);
        tick();
        drive(1'b1, 6'd8, 6'd0, 5'd1, 5'd4, 5'd0, 32'd1, 32'd0, 16'd1);
        #1 check("addi_rt_nostall", stall, 0);
        drive(1'b1, 6'd43, 6'd0, 5'd1, 5'd4, 5'd0, 32'd1, 32'd2, 16'd0);
        #1 check("sw_rt_stall", stall, 1);
        flush = 1'b1;
        #1 check("flush_stall", stall, 0);
        tick();
        check("flush_valid", ex_valid, 0);
        check("flush_memwrite", ex_memwrite, 0);
        check("flush_regwrite", ex_regwrite, 0);
        flush = 1'b0;

        // lw $0 never triggers load-use
        drive(1'b1, 6'd35, 6'd0, 5'd1, 5'd0, 5'd0, 32'd100, 32'd0, 16'd8);
        tick();
        drive(1'b1, 6'd0, 6'd32, 5'd0, 5'd0, 5'd5, 32'd0, 32'd0, 16'd0);
        #1 check("lw_r0_nostall", stall, 0);

        // sw $5,4($1), then async reset mid-cycle
        drive(1'b1, 6'd43, 6'd0, 5'd1, 5'd5, 5'd0, 32'd10, 32'd99, 16'd4);
        tick();
        check("sw_memwrite", ex_memwrite, 1);
        check("sw_store", ex_store_data, 99);
        check("sw_dataB", ex_dataB, 4);
        check("sw_dataA", ex_dataA, 10);
        #2 reset = 1'b0;
        #1;
        check("arst_memwrite", ex_memwrite, 0);
        check("arst_valid", ex_valid, 0);
        check("arst_dest", ex_dest, 0);
        check("arst_dataA", ex_dataA, 0);
        check("arst_stall", stall, 0);
        #1 reset = 1'b1;

        // slt $7,$1,$2 after release
        drive(1'b1, 6'd0, 6'd42, 5'd1, 5'd2, 5'd7, 32'd3, 32'd4, 16'd0);
        tick();
        check("slt_valid", ex_valid, 1);
        check("slt_signal", ex_signal, 42);
        check("slt_dest", ex_dest, 7);
        check("slt_regwrite", ex_regwrite, 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 Parameter DW, 32, datapath width.
REQ-002 Parameter RW, 5, register-index width.
REQ-003 clk  in  1  rising-edge clock.
REQ-004 reset  in  1  asynchronous, active-low reset.
REQ-005 id_valid  in  1  decode slot holds a real instruction.
REQ-006 id_opcode, id_funct  in  6 each  instruction opcode / function fields.
REQ-007 id_rs, id_rt, id_rd  in  RW each  register indices.
REQ-008 id_rs_data, id_rt_data  in  DW each  register-file read data.
REQ-009 id_imm  in  16  immediate field.
REQ-010 flush  in  1  kill the instruction entering EX (taken branch/jump).
REQ-011 exmem_regwrite, exmem_rd, exmem_result  in  1/RW/DW  EX/MEM write-back candidate.
REQ-012 memwb_regwrite, memwb_rd, memwb_result  in  1/RW/DW  MEM/WB write-back candidate.
REQ-013 stall  out  1  hold PC and IF/ID (combinational).
REQ-014 ex_valid, ex_regwrite, ex_memread, ex_memwrite, ex_branch  out  1 each  registered EX controls.
REQ-015 ex_signal  out  6  ALU Signal code (32 ADD, 34 SUB, 36 AND, 37 OR, 42 SLT).
REQ-016 ex_dataA, ex_dataB  out  DW each  forwarded ALU operands.
REQ-017 ex_store_data  out  DW  forwarded rt value for sw.
REQ-018 ex_dest  out  RW  destination register.

Function
REQ-019 Decode: R-type (opcode 0) -> ex_signal=funct, dest=rd, regwrite=1; lw (35) -> ADD, dest=rt, memread, regwrite; sw (43) -> ADD, memwrite; beq (4) -> SUB, branch; addi (8) -> ADD, dest=rt, regwrite; any other opcode -> bubble.
REQ-020 R-type funct outside {32,34,36,37,42} SHALL produce a bubble.
REQ-021 Immediate is sign-extended to DW; ex_dataB = forwarded rt for R-type/beq, sign-extended imm for lw/sw/addi.
REQ-022 Registered fields update on each rising clk edge when not stalled by a bubble rule; latency ID->EX is exactly one cycle.
REQ-023 Forwarding (combinational on registered rs/rt): EX/MEM match (regwrite=1, rd==reg, rd!=0) wins over MEM/WB match; else registered file data.
REQ-024 Register 0 is never forwarded; operand reads 0 from the file path.
REQ-025 Load-use: stall=1 when ex_valid & ex_memread & ex_dest!=0 & (ex_dest==id_rs | (ex_dest==id_rt & id instruction reads rt)) & id_valid.
REQ-026 During stall, next EX state is a bubble (ex_valid=0, all write/mem/branch controls 0); IF/ID holds the instruction externally.
REQ-027 flush=1 forces a bubble next cycle and forces stall=0; flush has priority over stall.
REQ-028 A bubble clears ex_regwrite/ex_memread/ex_memwrite/ex_branch; ex_dest, data fields may hold stale values.
REQ-029 id_valid=0 loads a bubble.

Reset
REQ-030 reset low SHALL immediately clear ex_valid, ex_regwrite, ex_memread, ex_memwrite, ex_branch, ex_dest=0, ex_signal=0, stored operands/imm=0.
REQ-031 stall SHALL be 0 while reset is low; reset mid-stall discards the held instruction's EX bubble with no residual state.
REQ-032 First edge after reset release loads the current ID inputs normally.

Structure
REQ-033 Opcode and ALU Signal constants (ADD/SUB/AND/OR/SLT, LW/SW/BEQ/ADDI/RTYPE) belong in a shared package used by this block and the ALU.
REQ-034 One sub-module, fwd_mux, SHALL implement the per-operand forwarding priority (instantiated twice).

Verification
REQ-035 add $3,$1,$2 with rs_data=5, rt_data=7 -> next cycle ex_signal=32, dataA=5, dataB=7, dest=3, regwrite=1.
REQ-036 EX/MEM rd=1 result=100 and MEM/WB rd=1 result=200 -> dataA=100; EX/MEM rd=0 result=9 -> no forward.
REQ-037 lw $4 in EX, ID sub $5,$4,$6 -> stall=1 one cycle, next ex_valid=0, then sub enters with MEM/WB forward of $4.
REQ-038 flush=1 coinciding with load-use stall -> stall=0, next ex_valid=0, no memwrite/regwrite.
REQ-039 addi $2,$0,-1 (imm 16'hFFFF) -> dataB=32'hFFFFFFFF, ex_signal=32; funct 6'd0 R-type -> bubble.
REQ-040 reset low asynchronously mid-cycle with valid sw in EX -> ex_memwrite=0 before next clk edge.
